video_palframe_banked: RTL and testbench
========================================

# video_palframe_banked

Parametrised palette/frame mixer for the video output path: selects pixel or border colour index, maps it through a multi-bank palette RAM and forces the output to zero during blanking. It sits between the pixel/border generators and the DAC/scandoubler. It extends the single-bank, write-only 4→6 bit palette with configurable index/colour widths, frame-synchronous bank switching, a host write port and a blank-time readback handshake.

## Interface
- IDX_W, 4, colour index width; palette has 2^IDX_W entries per bank
- COL_W, 6, output colour width
- BANK_W, 1, bank select width; 2^BANK_W banks; total depth 2^(BANK_W+IDX_W)
- clk  in  1  video clock (28 MHz); all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- hpix, vpix  in  1 each  pixel area flags; pixel area = hpix & vpix
- hblank, vblank  in  1 each  blanking flags
- pixels  in  IDX_W  pixel colour index
- border  in  IDX_W  border colour index
- zx_palwr  in  1  legacy write: store zx_paldata at [active bank][current mixed index]
- zx_paldata  in  COL_W  legacy write data
- pal_wr  in  1  host write strobe, one entry per cycle
- pal_waddr  in  BANK_W+IDX_W  host write address {bank, index}
- pal_wdata  in  COL_W  host write data
- bank_sel  in  BANK_W  requested display bank
- rd_req  in  1  readback request (level, held until rd_ack)
- rd_addr  in  BANK_W+IDX_W  readback address, stable while rd_req high
- rd_data  out  COL_W  readback data, valid when rd_ack=1
- rd_ack  out  1  one-cycle readback acknowledge
- active_bank  out  BANK_W  bank currently displayed
- color  out  COL_W  final colour, registered

## Operation
- Mix: idx = (hpix & vpix) ? pixels : border; blank = hblank | vblank.
- Stage 1 (registered): idx_r, blank_r, rd address select. Stage 2: palette RAM synchronous read; color = blank of that pixel ? 0 : RAM data.
- RAM: one write port, one read port. Read address = {active_bank, idx_r}, except in FSM state READ, where it is rd_addr.
- Write arbitration: pal_wr wins over zx_palwr in the same cycle; zx write is dropped. zx_palwr address = {active_bank, idx} of the same cycle.
- Read-during-write to the same entry returns old data (read-before-write), for both display and readback.
- Bank switch: bank_sel sampled on vblank rising edge (vblank=1, previous vblank=0); active_bank updates the next cycle. Never changes mid-frame.
- Readback FSM: IDLE → (rd_req) WAIT → (blank_r=1) READ → ACK → IDLE.
  - READ steals one RAM read; the slot is blanked, so the displayed color is 0 regardless.
  - ACK: rd_ack=1 for one cycle, rd_data = RAM output; rd_data holds until the next ACK.
  - From ACK, return to IDLE even if rd_req is still high. A new request needs rd_req to be low for ≥1 cycle. Requester drops rd_req the cycle after rd_ack.
- Widths: no arithmetic; indices zero-extended nowhere; BANK_W=0 is not supported.

## Timing
- Reset values: color=0, rd_ack=0, rd_data=0, active_bank=0, FSM=IDLE, vblank history=0. Palette contents undefined.
- Latency: inputs at edge N → color at edge N+2. Blanking travels through the same pipeline.
- Palette write visible to display reads issued ≥1 cycle after the write edge.
- Readback: if blank_r is already 1 when WAIT is entered, rd_ack asserts 3 cycles after rd_req rises. In all cases, ≤3 cycles after the next blanked stage-1 slot.
- Reset mid-readback: FSM returns to IDLE with no ack; the requester must re-request.
- bank_sel change together with a vblank rise: the new value is taken.

## Test plan
- Mix/blank: IDX_W=4, COL_W=6. Load entry 3=6'h15, entry 9=6'h2A. Then hpix=vpix=1, pixels=3, border=9 → color=6'h15 two cycles later. Set vpix=0 → 6'h2A. Set hblank=1 → 6'h00.
- Write arbitration: pal_wr (addr {0,5}, data 6'h3F) and zx_palwr (idx=5, data 6'h01) in the same cycle → entry 5 reads back 6'h3F.
- Bank swap: bank0 entry 2=6'h11, bank1 entry 2=6'h22, border=2. Set bank_sel=1 mid-frame → color stays 6'h11 until the vblank rise, then 6'h22. active_bank goes 0→1 one cycle after the rise.
- Readback: rd_req with rd_addr={1,2} during active video → no ack. After hblank rises → one-cycle rd_ack with rd_data=6'h22. Displayed pixels are unaffected.
- Reset: assert rst_n=0 while in WAIT → color=0, rd_ack=0, active_bank=0 immediately (asynchronous). No ack appears after release.
- Read-before-write: write entry 7 with 6'h0C while displaying index 7 (old value 6'h30) → color shows 6'h30 for that pixel and 6'h0C for the next one.

Source files
------------

// File: rtl/video_palframe_banked.sv
// video_palframe_banked: pixel/border mixer with multi-bank palette RAM, blanking and blank-time readback
//
// Ports:
//   clk, rst_n              video clock, asynchronous active-low reset
//   hpix, vpix              pixel area flags (pixel area = hpix & vpix)
//   hblank, vblank          blanking flags
//   pixels, border          pixel / border colour index
//   zx_palwr, zx_paldata    legacy write at {active_bank, mixed index}
//   pal_wr, pal_waddr,
//   pal_wdata               host write port, wins over the legacy write
//   bank_sel                requested bank, taken on a vblank rise
//   rd_req, rd_addr         readback request (level) and address
//   rd_data, rd_ack         readback data and one-cycle acknowledge
//   active_bank             bank currently displayed
//   color                   final colour, two cycles after the inputs
module video_palframe_banked #(
    parameter int IDX_W  = 4,
    parameter int COL_W  = 6,
    parameter int BANK_W = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hpix,
    input  logic                    vpix,
    input  logic                    hblank,
    input  logic                    vblank,
    input  logic [IDX_W-1:0]        pixels,
    input  logic [IDX_W-1:0]        border,
    input  logic                    zx_palwr,
    input  logic [COL_W-1:0]        zx_paldata,
    input  logic                    pal_wr,
    input  logic [BANK_W+IDX_W-1:0] pal_waddr,
    input  logic [COL_W-1:0]        pal_wdata,
    input  logic [BANK_W-1:0]       bank_sel,
    input  logic                    rd_req,
    input  logic [BANK_W+IDX_W-1:0] rd_addr,
    output logic [COL_W-1:0]        rd_data,
    output logic                    rd_ack,
    output logic [BANK_W-1:0]       active_bank,
    output logic [COL_W-1:0]        color
);
    localparam int AW = BANK_W + IDX_W;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] READ = 2'd2;
    localparam logic [1:0] ACK  = 2'd3;

    logic [COL_W-1:0] mem [2**AW];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_r;
    logic             blank_r;
    logic             vb_q;
    logic             req_q;
    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             rd_st;
    logic [AW-1:0]    raddr;
    logic [COL_W-1:0] rdat;

    assign idx   = (hpix & vpix) ? pixels : border;
    assign rd_st = state == READ;
    // the READ slot steals the single read port from the display
    assign raddr = rd_st ? rd_addr : {active_bank, idx_r};
    assign rdat  = mem[raddr];

    // a request is only taken on its rising level, so a held rd_req after ACK is ignored
    always_comb begin
        state_nx = (state == IDLE) ? ((rd_req & ~req_q) ? WAIT : IDLE) :
                   (state == WAIT) ? (blank_r ? READ : WAIT) :
                   (state == READ) ? ACK : IDLE;
    end

    // palette storage: unreset; reads in the same edge see the old entry
    always_ff @(posedge clk) begin
        if (pal_wr)
            mem[pal_waddr] <= pal_wdata;
        else if (zx_palwr)
            mem[{active_bank, idx}] <= zx_paldata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= '0;
            blank_r     <= 1'b1; // keep undefined palette data off the output after reset
            vb_q        <= 1'b0;
            req_q       <= 1'b0;
            state       <= IDLE;
            active_bank <= '0;
            color       <= '0;
            rd_data     <= '0;
            rd_ack      <= 1'b0;
        end else begin
            idx_r   <= idx;
            blank_r <= hblank | vblank;
            vb_q    <= vblank;
            req_q   <= rd_req;
            state   <= state_nx;
            if (vblank & ~vb_q)
                active_bank <= bank_sel;
            rd_ack  <= rd_st;
            color   <= (blank_r | rd_st) ? '0 : rdat;
            if (rd_st)
                rd_data <= rdat;
        end
    end
endmodule

// File: tb/tb_video_palframe_banked.sv
// tb_video_palframe_banked: randomized and directed self-checking bench for video_palframe_banked
module tb_video_palframe_banked;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       hpix, vpix, hblank, vblank;
    logic [3:0] pixels, border;
    logic       zx_palwr;
    logic [5:0] zx_paldata;
    logic       pal_wr;
    logic [4:0] pal_waddr;
    logic [5:0] pal_wdata;
    logic [0:0] bank_sel;
    logic       rd_req;
    logic [4:0] rd_addr;
    logic [5:0] rd_data;
    logic       rd_ack;
    logic [0:0] active_bank;
    logic [5:0] color;

    logic [5:0] ref_mem [32];
    logic       ref_bank;
    int         checks = 0;
    int         failures = 0;

    video_palframe_banked dut (
        .clk(clk), .rst_n(rst_n), .hpix(hpix), .vpix(vpix), .hblank(hblank), .vblank(vblank),
        .pixels(pixels), .border(border), .zx_palwr(zx_palwr), .zx_paldata(zx_paldata),
        .pal_wr(pal_wr), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata), .bank_sel(bank_sel),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
        .active_bank(active_bank), .color(color)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // colour the display should show once the current inputs have settled for two cycles
    function automatic logic [5:0] exp_color();
        logic [3:0] i;
        i = (hpix & vpix) ? pixels : border;
        return (hblank | vblank) ? 6'h00 : ref_mem[{ref_bank, i}];
    endfunction

    task automatic pal_write(input logic [4:0] a, input logic [5:0] d);
        pal_wr = 1'b1; pal_waddr = a; pal_wdata = d;
        tick();
        pal_wr = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {hpix, vpix, hblank, vblank, zx_palwr, pal_wr, rd_req} = '0;
        pixels = '0; border = '0; zx_paldata = '0; pal_waddr = '0; pal_wdata = '0;
        bank_sel = '0; rd_addr = '0; ref_bank = 1'b0;
        #1;
        checks++; if (color !== 6'h00) begin failures++; $display("FAIL reset_color got=%h exp=00", color); end
        checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", rd_ack); end
        checks++; if (rd_data !== 6'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        checks++; if (active_bank !== 1'b0) begin failures++; $display("FAIL reset_bank got=%b exp=0", active_bank); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 32; a++) pal_write(5'(a), 6'($urandom));
    endtask

    task automatic test_mix();
        logic [5:0] e;
        pal_write(5'd3, 6'h15);
        pal_write(5'd9, 6'h2A);
        hpix = 1; vpix = 1; pixels = 4'd3; border = 4'd9; hblank = 0; vblank = 0;
        tick(); tick();
        checks++; if (color !== 6'h15) begin failures++; $display("FAIL mix_pixel got=%h exp=15", color); end
        vpix = 0;
        tick(); tick();
        checks++; if (color !== 6'h2A) begin failures++; $display("FAIL mix_border got=%h exp=2a", color); end
        hblank = 1;
        tick(); tick();
        checks++; if (color !== 6'h00) begin failures++; $display("FAIL mix_blank got=%h exp=00", color); end
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(1, 0) == 1) pal_write(5'($urandom), 6'($urandom));
            hpix = 1'($urandom); vpix = 1'($urandom);
            hblank = ($urandom_range(3, 0) == 0); vblank = ($urandom_range(3, 0) == 0);
            pixels = 4'($urandom); border = 4'($urandom);
            tick(); tick();
            e = exp_color();
            checks++; if (color !== e) begin failures++; $display("FAIL mix_rand%0d got=%h exp=%h", n, color, e); end
        end
        hblank = 0; vblank = 0;
        tick();
    endtask

    task automatic test_arb();
        logic [5:0] d;
        hpix = 1; vpix = 1; pixels = 4'd5;
        pal_wr = 1; pal_waddr = 5'd5; pal_wdata = 6'h3F;
        zx_palwr = 1; zx_paldata = 6'h01;
        tick();
        pal_wr = 0; zx_palwr = 0; ref_mem[5] = 6'h3F;
        tick(); tick();
        checks++; if (color !== 6'h3F) begin failures++; $display("FAIL arb_same got=%h exp=3f", color); end
        d = 6'($urandom);
        if (d == 6'h3F) d = 6'h01;
        zx_palwr = 1; zx_paldata = d;
        tick();
        zx_palwr = 0; ref_mem[5] = d;
        tick(); tick();
        checks++; if (color !== d) begin failures++; $display("FAIL arb_zx_only got=%h exp=%h", color, d); end
        pal_wr = 1; pal_waddr = 5'd9; pal_wdata = 6'h07;
        zx_palwr = 1; zx_paldata = ~d;
        tick();
        pal_wr = 0; zx_palwr = 0; ref_mem[9] = 6'h07;
        tick(); tick();
        checks++; if (color !== d) begin failures++; $display("FAIL arb_zx_dropped got=%h exp=%h", color, d); end
        pixels = 4'd9;
        tick(); tick();
        checks++; if (color !== 6'h07) begin failures++; $display("FAIL arb_host_other got=%h exp=07", color); end
    endtask

    task automatic test_bank();
        logic [5:0] d;
        pal_write(5'd2, 6'h11);
        pal_write(5'd18, 6'h22);
        hpix = 0; border = 4'd2; hblank = 0; vblank = 0; bank_sel = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (n > 0) begin
                checks++; if (color !== 6'h11) begin failures++; $display("FAIL bank_hold%0d got=%h exp=11", n, color); end
                checks++; if (active_bank !== 1'b0) begin failures++; $display("FAIL bank_hold_ab%0d got=%b exp=0", n, active_bank); end
            end
        end
        vblank = 1;
        tick();
        ref_bank = 1'b1;
        checks++; if (active_bank !== 1'b1) begin failures++; $display("FAIL bank_switch got=%b exp=1", active_bank); end
        vblank = 0; bank_sel = 1'b0;
        tick(); tick();
        checks++; if (color !== 6'h22) begin failures++; $display("FAIL bank_new_color got=%h exp=22", color); end
        checks++; if (active_bank !== 1'b1) begin failures++; $display("FAIL bank_no_rise got=%b exp=1", active_bank); end
        d = 6'($urandom);
        border = 4'd6; zx_palwr = 1; zx_paldata = d;
        tick();
        zx_palwr = 0; ref_mem[{1'b1, 4'd6}] = d;
        tick(); tick();
        checks++; if (color !== d) begin failures++; $display("FAIL bank_zx_write got=%h exp=%h", color, d); end
        vblank = 1; bank_sel = 1'b0;
        tick();
        checks++; if (active_bank !== 1'b0) begin failures++; $display("FAIL bank_same_cycle0 got=%b exp=0", active_bank); end
        vblank = 0;
        tick();
        vblank = 1; bank_sel = 1'b1;
        tick();
        checks++; if (active_bank !== 1'b1) begin failures++; $display("FAIL bank_same_cycle1 got=%b exp=1", active_bank); end
        vblank = 0; border = 4'd2; ref_bank = 1'b1;
        tick();
    endtask

    task automatic test_readback();
        logic [5:0] e;
        logic       got;
        int         lat;
        hpix = 1; vpix = 1; pixels = 4'd4; hblank = 0; vblank = 0;
        tick(); tick();
        rd_req = 1; rd_addr = {1'b1, 4'd2};
        for (int n = 0; n < 8; n++) begin
            tick();
            e = exp_color();
            checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL rb_active_ack%0d got=%b exp=0", n, rd_ack); end
            checks++; if (color !== e) begin failures++; $display("FAIL rb_active_color%0d got=%h exp=%h", n, color, e); end
        end
        hblank = 1;
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            tick();
            got = rd_ack;
        end
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL rb_ack_seen got=%b exp=1", got); end
        checks++; if (rd_data !== 6'h22) begin failures++; $display("FAIL rb_data got=%h exp=22", rd_data); end
        rd_req = 0;
        tick();
        checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL rb_ack_one_cycle got=%b exp=0", rd_ack); end
        checks++; if (rd_data !== 6'h22) begin failures++; $display("FAIL rb_data_hold got=%h exp=22", rd_data); end
        checks++; if (color !== 6'h00) begin failures++; $display("FAIL rb_blank_color got=%h exp=00", color); end
        for (int n = 0; n < 6; n++) begin
            rd_addr = 5'($urandom);
            rd_req = 1;
            lat = 99;
            for (int c = 1; c <= 6 && lat == 99; c++) begin
                tick();
                if (rd_ack) lat = c;
            end
            checks++; if (lat != 3) begin failures++; $display("FAIL rb_latency%0d got=%0d exp=3", n, lat); end
            checks++; if (rd_data !== ref_mem[rd_addr]) begin failures++; $display("FAIL rb_rand_data%0d got=%h exp=%h", n, rd_data, ref_mem[rd_addr]); end
            rd_req = 0;
            tick();
        end
        hblank = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        pal_write({1'b1, 4'd4}, 6'h2D);
        hpix = 1; vpix = 1; pixels = 4'd4; hblank = 0; vblank = 0; bank_sel = 1'b0;
        tick(); tick();
        checks++; if (color !== 6'h2D) begin failures++; $display("FAIL rm_pre_color got=%h exp=2d", color); end
        rd_req = 1; rd_addr = 5'($urandom);
        tick(); tick(); tick();
        #2;
        rst_n = 0; rd_req = 0;
        #1;
        ref_bank = 1'b0;
        checks++; if (color !== 6'h00) begin failures++; $display("FAIL rm_color got=%h exp=00", color); end
        checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL rm_ack got=%b exp=0", rd_ack); end
        checks++; if (active_bank !== 1'b0) begin failures++; $display("FAIL rm_bank got=%b exp=0", active_bank); end
        tick();
        rst_n = 1;
        hblank = 1;
        got_none: for (int n = 0; n < 8; n++) begin
            tick();
            checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL rm_no_ack%0d got=%b exp=0", n, rd_ack); end
        end
        hblank = 0;
        tick();
    endtask

    task automatic test_rbw();
        pal_write(5'd7, 6'h30);
        hpix = 1; vpix = 1; pixels = 4'd7; hblank = 0; vblank = 0;
        tick(); tick();
        checks++; if (color !== 6'h30) begin failures++; $display("FAIL rbw_before got=%h exp=30", color); end
        pal_wr = 1; pal_waddr = 5'd7; pal_wdata = 6'h0C;
        tick();
        pal_wr = 0; ref_mem[7] = 6'h0C;
        checks++; if (color !== 6'h30) begin failures++; $display("FAIL rbw_old got=%h exp=30", color); end
        tick();
        checks++; if (color !== 6'h0C) begin failures++; $display("FAIL rbw_new got=%h exp=0c", color); end
    endtask

    initial begin
        test_reset();
        test_mix();
        test_arb();
        test_bank();
        test_readback();
        test_reset_mid();
        test_rbw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
